// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types, keycodes and the per-axis move/bounce function for sprite_motion.
// Wrap behaviour of axis_step is selected by the SPRITE_MOTION_WRAP_EN macro.
package sprite_pkg;
  typedef logic [9:0] coord_t;
  typedef logic signed [9:0] vel_t;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;
  typedef struct packed {
    coord_t pos;
    vel_t vel;
    logic hit;
  } axis_t;
  // One-axis step; 11-bit signed sum so pos+vel cannot wrap below zero.
  function automatic axis_t axis_step(coord_t pos, vel_t vel, coord_t lo, coord_t hi);
    logic signed [10:0] nxt;
    logic over;
    logic under;
    axis_t r;
    nxt = $signed({1'b0, pos}) + $signed({vel[9], vel});
    over = nxt > $signed({1'b0, hi});
    under = nxt < $signed({1'b0, lo});
    r.hit = over | under;
`ifdef SPRITE_MOTION_WRAP_EN
    r.pos = over ? lo : under ? hi : nxt[9:0];
    r.vel = vel;
`else
    r.pos = over ? hi : under ? lo : nxt[9:0];
    r.vel = r.hit ? -vel : vel;
`endif
    return r;
  endfunction
endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: 2-flop synchroniser plus history flop on vs; tick is a one-cycle pulse per falling edge.
// Ports: clk, rst_n (async active-low), vs (async input), tick (registered-domain pulse).
module frame_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic vs,
  output logic tick
);
  logic s1, s2, s3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= vs;
      s2 <= s1;
      s3 <= s2;
    end
  end
  // Reset clears s3, so vs must be seen high again before a tick can fire.
  assign tick = s3 & ~s2;
endmodule

// File: rtl/sprite_motion.sv
// sprite_motion: per-frame sprite centre/velocity update from keycode with playfield bounce (or wrap).
// Ports: Clk, Reset_n (async active-low), frame_vs (active-low vsync), keycode, pause,
//        PosX/PosY (centre), Size (half-size), VelX/VelY (signed velocity), bounce (one-cycle event).
// Define SPRITE_MOTION_WRAP_EN for wrap-around instead of bounce at the playfield limits.
module sprite_motion
  import sprite_pkg::*;
#(
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 639,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 479,
  parameter int SIZE    = 4,
  parameter int STEP    = 1,
  parameter int X_START = 320,
  parameter int Y_START = 240
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_vs,
  input  logic [7:0] keycode,
  input  logic       pause,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic [9:0] Size,
  output logic signed [9:0] VelX,
  output logic signed [9:0] VelY,
  output logic       bounce
);
  localparam coord_t LO_X = coord_t'(X_MIN + SIZE);
  localparam coord_t HI_X = coord_t'(X_MAX - SIZE);
  localparam coord_t LO_Y = coord_t'(Y_MIN + SIZE);
  localparam coord_t HI_Y = coord_t'(Y_MAX - SIZE);
  localparam vel_t   STEP_V = vel_t'(STEP);
  if ((X_MIN + SIZE > X_MAX - SIZE) || (Y_MIN + SIZE > Y_MAX - SIZE) ||
      (STEP > (X_MAX - X_MIN) / 2) || (STEP > (Y_MAX - Y_MIN) / 2)) begin : g_bad_params
    $error("sprite_motion: illegal playfield/size/step parameters");
  end
  logic tick;
  logic upd;
  vel_t kvx, kvy;
  axis_t ax, ay;
  frame_tick_sync u_sync (
    .clk  (Clk),
    .rst_n(Reset_n),
    .vs   (frame_vs),
    .tick (tick)
  );
  assign upd = tick & ~pause;
  assign Size = coord_t'(SIZE);
  // Key selects the velocity first, so a key into a wall bounces on this same tick.
  always_comb begin
    kvx = keycode == KEY_A ? -STEP_V : keycode == KEY_D ? STEP_V :
          (keycode == KEY_W || keycode == KEY_S) ? vel_t'(0) : VelX;
    kvy = keycode == KEY_W ? -STEP_V : keycode == KEY_S ? STEP_V :
          (keycode == KEY_A || keycode == KEY_D) ? vel_t'(0) : VelY;
    ax = axis_step(PosX, kvx, LO_X, HI_X);
    ay = axis_step(PosY, kvy, LO_Y, HI_Y);
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      PosX   <= coord_t'(X_START);
      PosY   <= coord_t'(Y_START);
      VelX   <= '0;
      VelY   <= STEP_V;
      bounce <= 1'b0;
    end else begin
      bounce <= upd & (ax.hit | ay.hit);
      if (upd) begin
        PosX <= ax.pos;
        PosY <= ay.pos;
        VelX <= ax.vel;
        VelY <= ay.vel;
      end
    end
  end
endmodule

// File: tb/tb_sprite_motion.sv
// tb_sprite_motion: directed + randomized frames against an integer reference model, two DUTs (default start, out-of-range corner start).
module tb_sprite_motion;
  logic clk = 1'b0;
  logic rst_n, frame_vs, pause;
  logic [7:0] keycode;
  logic [9:0] pos_x [2];
  logic [9:0] pos_y [2];
  logic [9:0] sz [2];
  logic [9:0] vel_x [2];
  logic [9:0] vel_y [2];
  logic bnc [2];
  int total = 0;
  int bad = 0;
  int bcnt [2] = '{0, 0};
  int m_px [2], m_py [2], m_vx [2], m_vy [2];
  bit m_ev [2];
  int sx [2] = '{320, 700};
  int sy [2] = '{240, 479};
  logic [7:0] keys [6] = '{8'h00, 8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C};

  always #10 clk = ~clk;
  always @(posedge clk) for (int d = 0; d < 2; d++) if (bnc[d]) bcnt[d]++;

  sprite_motion dut0 (
    .Clk(clk), .Reset_n(rst_n), .frame_vs(frame_vs), .keycode(keycode), .pause(pause),
    .PosX(pos_x[0]), .PosY(pos_y[0]), .Size(sz[0]), .VelX(vel_x[0]), .VelY(vel_y[0]), .bounce(bnc[0])
  );
  sprite_motion #(.X_START(700), .Y_START(479)) dut1 (
    .Clk(clk), .Reset_n(rst_n), .frame_vs(frame_vs), .keycode(keycode), .pause(pause),
    .PosX(pos_x[1]), .PosY(pos_y[1]), .Size(sz[1]), .VelX(vel_x[1]), .VelY(vel_y[1]), .bounce(bnc[1])
  );

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_px[d] = sx[d]; m_py[d] = sy[d]; m_vx[d] = 0; m_vy[d] = 1;
    end
  endfunction

  function automatic bit axis_m(inout int p, inout int v, input int lo, input int hi);
    int n = p + v;
    if (n > hi || n < lo) begin
`ifdef SPRITE_MOTION_WRAP_EN
      p = (n > hi) ? lo : hi;
`else
      p = (n > hi) ? hi : lo;
      v = -v;
`endif
      return 1'b1;
    end
    p = n;
    return 1'b0;
  endfunction

  function automatic void model_frame();
    for (int d = 0; d < 2; d++) begin
      m_ev[d] = 1'b0;
      if (!pause) begin
        case (keycode)
          8'h1A: begin m_vx[d] = 0;  m_vy[d] = -1; end
          8'h16: begin m_vx[d] = 0;  m_vy[d] = 1;  end
          8'h04: begin m_vx[d] = -1; m_vy[d] = 0;  end
          8'h07: begin m_vx[d] = 1;  m_vy[d] = 0;  end
          default: ;
        endcase
        m_ev[d] = axis_m(m_px[d], m_vx[d], 4, 635);
        m_ev[d] = axis_m(m_py[d], m_vy[d], 4, 475) | m_ev[d];
      end
    end
  endfunction

  task automatic check_state(string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_posx%0d", tag, d), int'(pos_x[d]), m_px[d]);
      chk($sformatf("%s_posy%0d", tag, d), int'(pos_y[d]), m_py[d]);
      chk($sformatf("%s_velx%0d", tag, d), int'($signed(vel_x[d])), m_vx[d]);
      chk($sformatf("%s_vely%0d", tag, d), int'($signed(vel_y[d])), m_vy[d]);
    end
  endtask

  task automatic frame(int h, int l);
    @(negedge clk) frame_vs = 1'b1;
    repeat (h - 1) @(negedge clk);
    frame_vs = 1'b0;
    repeat (l) @(negedge clk);
    frame_vs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(string tag, int h, int l);
    int b0 [2];
    b0 = bcnt;
    frame(h, l);
    model_frame();
    check_state(tag);
    for (int d = 0; d < 2; d++) chk($sformatf("%s_bounce%0d", tag, d), bcnt[d] - b0[d], int'(m_ev[d]));
  endtask

  initial begin
    int old_x;
    int b0 [2];
    int guard;
    rst_n = 1'b0; frame_vs = 1'b1; keycode = 8'h00; pause = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("rst");
    chk("rst_bounce", int'(bnc[0]), 0);
    chk("size", int'(sz[0]), 4);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_state("rel");

    for (int i = 0; i < 3; i++) run_frame("nokey", 2, 3);
    chk("nokey_posy_243", int'(pos_y[0]), 243);
    chk("nokey_posx_320", int'(pos_x[0]), 320);
    chk("corner_posx", int'(pos_x[1]), 635);

    keycode = 8'h07;
    old_x = m_px[0];
    b0 = bcnt;
    @(negedge clk) frame_vs = 1'b1;
    repeat (2) @(negedge clk);
    frame_vs = 1'b0;
    @(posedge clk); #1 chk("lat_k", int'(pos_x[0]), old_x);
    @(posedge clk); #1 chk("lat_k1", int'(pos_x[0]), old_x);
    @(posedge clk); #1 chk("lat_k2", int'(pos_x[0]), old_x + 1);
    @(negedge clk) frame_vs = 1'b1;
    repeat (3) @(negedge clk);
    model_frame();
    check_state("lat");
    for (int d = 0; d < 2; d++) chk($sformatf("lat_bounce%0d", d), bcnt[d] - b0[d], int'(m_ev[d]));
    for (int i = 0; i < 4; i++) run_frame("keyd", 1, 2);
    chk("keyd_posx_325", int'(pos_x[0]), 325);
    chk("keyd_vely_0", int'($signed(vel_y[0])), 0);

    guard = 0;
    while (m_px[0] < 634 && guard < 400) begin
      frame(1, 1);
      model_frame();
      guard++;
    end
    check_state("walk");
    chk("walk_posx_634", int'(pos_x[0]), 634);
    run_frame("edge", 2, 2);
    chk("edge_posx_635", int'(pos_x[0]), 635);
    keycode = 8'h00;
    run_frame("hit", 2, 2);
`ifdef SPRITE_MOTION_WRAP_EN
    chk("hit_posx", int'(pos_x[0]), 4);
    chk("hit_velx", int'($signed(vel_x[0])), 1);
`else
    chk("hit_posx", int'(pos_x[0]), 635);
    chk("hit_velx", int'($signed(vel_x[0])), -1);
`endif

    run_frame("longlow", 2, 1000);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) run_frame("pause", 2, 3);
    pause = 1'b0;

    @(negedge clk) frame_vs = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_state("midrst");
    rst_n = 1'b1;
    b0 = bcnt;
    repeat (10) @(negedge clk);
    check_state("postrst");
    for (int d = 0; d < 2; d++) chk($sformatf("postrst_bounce%0d", d), bcnt[d] - b0[d], 0);
    run_frame("firstafter", 2, 2);

    for (int i = 0; i < 80; i++) begin
      keycode = keys[$urandom_range(0, 5)];
      pause = ($urandom_range(0, 4) == 0);
      run_frame("rand", int'($urandom_range(1, 5)), int'($urandom_range(1, 6)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
